stopwatch_ctrl: RTL and testbench

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_pkg.sv | 15 +
 rtl/edge_det.sv | 25 ++
 rtl/stopwatch_ctrl.sv | 142 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared types and constants for the stopwatch controller.
//   state_e      FSM state encoding (also driven onto the state port)
//   DIV_DEFAULT  default clk cycles per ce_tick (100 Hz at 100 MHz)
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_DONE  = 2'b11
   } state_e;

   localparam int unsigned DIV_DEFAULT = 1_000_000;

endpackage

// File: rtl/edge_det.sv
// edge_det: rising-edge detector for an already synchronized, debounced input.
// The previous-value register resets to 1 so a level held through reset
// does not register as an edge.
//   clk       system clock
//   rst       synchronous active-high reset
//   d_i       level input
//   rise_c_o  combinational pulse: d_i high now, low last cycle
module edge_det (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic rise_c_o
);

   logic prev_q;

   // Previous-value register
   always_ff @(posedge clk) begin
      if (rst) prev_q <= 1'b1;
      else     prev_q <= d_i;
   end

   assign rise_c_o = d_i & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: control FSM and tick prescaler for a BCD stopwatch datapath.
// Optional lap feature enabled by defining STOPWATCH_LAP_EN.
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   btn_ss     start/stop button       btn_clr  clear button
//   btn_lap    lap button              ud_mode  requested direction (1 = up)
//   zero_flag  all datapath digits are 0
//   ce_tick    enable for the least-significant digit counter (combinational)
//   ud         direction to digit counters, latched at start
//   cnt_clr    one-cycle clear pulse to digit counters
//   lap_hold   freeze display register while counting continues
//   state      current FSM state
//   done       one-cycle pulse when a countdown reaches zero
module stopwatch_ctrl
   import stopwatch_pkg::*;
#(
   parameter int unsigned DIV = DIV_DEFAULT
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_ss,
   input  logic       btn_clr,
   input  logic       btn_lap,
   input  logic       ud_mode,
   input  logic       zero_flag,
   output logic       ce_tick,
   output logic       ud,
   output logic       cnt_clr,
   output logic       lap_hold,
   output logic [1:0] state,
   output logic       done
);

   localparam int unsigned PW = $clog2(DIV);

   state_e          state_q, state_d;
   logic [PW-1:0]   psc_q, psc_d;
   logic            ud_q, ud_d;
   logic            cnt_clr_q, cnt_clr_d;
   logic            lap_q, lap_d;
   logic            done_q, done_d;

   logic            ss_rise, clr_rise, lap_rise;
   logic            psc_wrap, count_end;

   edge_det u_ss  (.clk(clk), .rst(rst), .d_i(btn_ss),  .rise_c_o(ss_rise));
   edge_det u_clr (.clk(clk), .rst(rst), .d_i(btn_clr), .rise_c_o(clr_rise));
   edge_det u_lap (.clk(clk), .rst(rst), .d_i(btn_lap), .rise_c_o(lap_rise));

   assign psc_wrap  = (psc_q == PW'(DIV - 1));
   // Countdown has reached zero: no further ticks, head to DONE
   assign count_end = ~ud_q & zero_flag;

   // State and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         psc_q     <= '0;
         ud_q      <= 1'b1;
         cnt_clr_q <= 1'b0;
         lap_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         psc_q     <= psc_d;
         ud_q      <= ud_d;
         cnt_clr_q <= cnt_clr_d;
         lap_q     <= lap_d;
         done_q    <= done_d;
      end
   end

   // Next-state, prescaler and pulse logic; clear dominates every other event
   always_comb begin
      state_d   = state_q;
      psc_d     = psc_q;
      ud_d      = ud_q;
      cnt_clr_d = 1'b0;
      lap_d     = lap_q;
      done_d    = 1'b0;

      if (clr_rise) begin
         state_d   = ST_IDLE;
         psc_d     = '0;
         cnt_clr_d = 1'b1;
         lap_d     = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               psc_d = '0;
               lap_d = 1'b0;
               // A countdown from zero has nothing to count
               if (ss_rise && (ud_mode || !zero_flag)) begin
                  state_d = ST_RUN;
                  ud_d    = ud_mode;
               end
            end
            ST_RUN: begin
               if (count_end) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
                  psc_d   = '0;
               end else if (ss_rise) begin
                  // Pause freezes the count; a tick issued this cycle is consumed
                  state_d = ST_PAUSE;
                  psc_d   = psc_wrap ? '0 : psc_q;
               end else begin
                  psc_d = psc_wrap ? '0 : psc_q + PW'(1);
               end
            end
            ST_PAUSE: begin
               if (ss_rise) state_d = ST_RUN;
            end
            ST_DONE: begin
               psc_d = '0;
            end
            default: state_d = ST_IDLE;
         endcase

`ifdef STOPWATCH_LAP_EN
         if (lap_rise) begin
            if (state_q == ST_RUN)        lap_d = ~lap_q;
            else if (state_q == ST_PAUSE) lap_d = 1'b0;
         end
`endif
      end
   end

`ifndef STOPWATCH_LAP_EN
   // Lap button kept for a uniform port list; unused in this build
   logic unused_lap;
   assign unused_lap = lap_rise;
`endif

   assign ce_tick  = (state_q == ST_RUN) & psc_wrap & ~count_end;
   assign ud       = ud_q;
   assign cnt_clr  = cnt_clr_q;
   assign lap_hold = lap_q;
   assign state    = state_q;
   assign done     = done_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed scenarios plus random stimulus against a
// cycle-level behavioural model of the stopwatch controller (DIV = 4).
module tb_stopwatch_ctrl;

   localparam int DIV = 4;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_DONE = 3;
`ifdef STOPWATCH_LAP_EN
   localparam logic LAP_ON = 1'b1;
`else
   localparam logic LAP_ON = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst, btn_ss, btn_clr, btn_lap, ud_mode, zero_flag;
   logic       ce_tick, ud, cnt_clr, lap_hold, done;
   logic [1:0] state;

   stopwatch_ctrl #(.DIV(DIV)) dut (
      .clk(clk), .rst(rst), .btn_ss(btn_ss), .btn_clr(btn_clr),
      .btn_lap(btn_lap), .ud_mode(ud_mode), .zero_flag(zero_flag),
      .ce_tick(ce_tick), .ud(ud), .cnt_clr(cnt_clr), .lap_hold(lap_hold),
      .state(state), .done(done)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model: state as a plain integer, phase = cycles spent running mod DIV
   bit m_valid = 0;
   int m_state, m_phase;
   bit m_ud, m_lap, m_clr, m_done;
   bit p_ss, p_clr, p_lap;
   bit last_tick;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input bit r, ss, clr, lap, udm, zf);
      bit e_ss, e_clr, e_lap;
      e_ss = ss & !p_ss; e_clr = clr & !p_clr; e_lap = lap & !p_lap;
      p_ss = ss; p_clr = clr; p_lap = lap;
      m_clr = 0; m_done = 0;
      if (r) begin
         m_valid = 1; m_state = S_IDLE; m_phase = 0; m_ud = 1; m_lap = 0;
         p_ss = 1; p_clr = 1; p_lap = 1;
      end else if (e_clr) begin
         m_state = S_IDLE; m_phase = 0; m_lap = 0; m_clr = 1;
      end else begin
         if (LAP_ON && e_lap) begin
            if (m_state == S_RUN) m_lap = !m_lap;
            else if (m_state == S_PAUSE) m_lap = 0;
         end
         case (m_state)
            S_IDLE: if (e_ss && (udm || !zf)) begin
               m_state = S_RUN; m_ud = udm; m_phase = 0;
            end
            S_RUN: if (!m_ud && zf) begin
               m_state = S_DONE; m_done = 1; m_phase = 0;
            end else if (e_ss) begin
               m_state = S_PAUSE;
               if (m_phase == DIV - 1) m_phase = 0;
            end else begin
               m_phase = (m_phase + 1) % DIV;
            end
            S_PAUSE: if (e_ss) m_state = S_RUN;
            default: ;
         endcase
      end
   endtask

   // One clock cycle: drive inputs, compare against the model, advance the model
   task automatic step(input bit r, ss, clr, lap, udm, zf, input string tag);
      logic [5:0] exp_v, obs_v;
      bit exp_tick;
      rst = r; btn_ss = ss; btn_clr = clr; btn_lap = lap; ud_mode = udm; zero_flag = zf;
      #1;
      exp_tick = (m_state == S_RUN) && (m_phase == DIV - 1) && !(!m_ud && zf);
      exp_v = {2'(m_state), m_ud, exp_tick, m_clr, m_lap, m_done};
      obs_v = {state, ud, ce_tick, cnt_clr, lap_hold, done};
      if (m_valid) chk(tag, 32'(obs_v), 32'(exp_v));
      last_tick = ce_tick;
      @(posedge clk);
      model_edge(r, ss, clr, lap, udm, zf);
      #1;
   endtask

   task automatic watch(input int n, input bit udm, zf, input string tag,
                        output int first, output int cnt);
      first = -1; cnt = 0;
      for (int i = 1; i <= n; i++) begin
         step(0, 0, 0, 0, udm, zf, tag);
         if (last_tick) begin
            cnt++;
            if (first < 0) first = i;
         end
      end
   endtask

   initial begin
      int first, cnt, ndone;

      // Reset held with btn_ss high through deassertion
      step(1, 1, 0, 0, 1, 0, "rst");
      step(1, 1, 0, 0, 1, 0, "rst");
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1, 0, "rst_hold");
      chk("rst_hold_state", 32'(state), 32'(0));
      chk("rst_hold_tick", 32'(ce_tick), 32'(0));
      step(0, 0, 0, 0, 1, 0, "idle");

      // Start counting up: first tick 4 cycles after the edge, then every 4th
      step(0, 1, 0, 0, 1, 0, "start");
      chk("start_state", 32'(state), 32'(1));
      chk("start_ud", 32'(ud), 32'(1));
      watch(12, 1, 0, "run_up", first, cnt);
      chk("first_tick", 32'(first), 32'(4));
      chk("tick_count", 32'(cnt), 32'(3));

      // Pause with prescaler at 2, resume: next tick 2 cycles later
      step(0, 0, 1, 0, 1, 0, "clr0");
      step(0, 0, 0, 0, 1, 0, "idle");
      step(0, 1, 0, 0, 1, 0, "start2");
      step(0, 0, 0, 0, 1, 0, "p0");
      step(0, 0, 0, 0, 1, 0, "p1");
      step(0, 1, 0, 0, 1, 0, "pause");
      watch(5, 1, 0, "paused", first, cnt);
      chk("pause_state", 32'(state), 32'(2));
      chk("pause_ticks", 32'(cnt), 32'(0));
      step(0, 1, 0, 0, 0, 0, "resume");
      chk("resume_ud", 32'(ud), 32'(1));
      watch(6, 1, 0, "resumed", first, cnt);
      chk("resume_tick", 32'(first), 32'(2));

      // Clear priority over simultaneous start/stop
      step(0, 1, 1, 0, 1, 0, "clr_ss");
      chk("clr_state", 32'(state), 32'(0));
      chk("clr_pulse", 32'(cnt_clr), 32'(1));
      step(0, 0, 0, 0, 1, 0, "idle");
      chk("clr_pulse_end", 32'(cnt_clr), 32'(0));
      step(0, 1, 0, 0, 1, 0, "start3");
      watch(4, 1, 0, "after_clr", first, cnt);
      chk("clr_psc_zero", 32'(first), 32'(4));

      // Countdown to zero
      step(0, 0, 1, 0, 0, 0, "clr1");
      step(0, 0, 0, 0, 0, 0, "idle");
      step(0, 1, 0, 0, 0, 0, "start_dn");
      chk("dn_ud", 32'(ud), 32'(0));
      watch(6, 0, 0, "run_dn", first, cnt);
      chk("dn_ticks", 32'(cnt), 32'(1));
      ndone = 0; cnt = 0;
      for (int i = 0; i < 6; i++) begin
         step(0, 0, 0, 0, 1, 1, "zero");
         if (last_tick) cnt++;
         if (done) ndone++;
      end
      chk("done_state", 32'(state), 32'(3));
      chk("done_once", 32'(ndone), 32'(1));
      chk("done_no_tick", 32'(cnt), 32'(0));
      step(0, 1, 0, 0, 1, 1, "done_ss");
      chk("done_ss_ignored", 32'(state), 32'(3));

      // Lap in RUN, cleared by clear
      step(0, 0, 1, 0, 1, 0, "clr2");
      step(0, 0, 0, 0, 1, 0, "idle");
      step(0, 1, 0, 0, 1, 0, "start_lap");
      watch(2, 1, 0, "lap_pre", first, cnt);
      step(0, 0, 0, 1, 1, 0, "lap");
      chk("lap_set", 32'(lap_hold), 32'(LAP_ON));
      watch(8, 1, 0, "lap_run", first, cnt);
      chk("lap_ticks", 32'(cnt), 32'(2));
      step(0, 0, 1, 0, 1, 0, "lap_clr");
      chk("lap_cleared", 32'(lap_hold), 32'(0));

      // Random stimulus against the model
      for (int i = 0; i < 2000; i++) begin
         bit r, ss, clr, lap, udm, zf;
         r   = ($urandom_range(0, 249) == 0);
         ss  = ($urandom_range(0, 5) == 0);
         clr = ($urandom_range(0, 39) == 0);
         lap = ($urandom_range(0, 4) == 0);
         udm = 1'($urandom_range(0, 1));
         zf  = ($urandom_range(0, 11) == 0);
         step(r, ss, clr, lap, udm, zf, "random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
